mem_rd_sched: RTL and testbench
===============================

// Module: mem_rd_sched
// PURPOSE
//  Round-robin burst read scheduler for the read port (port B) of the dual-port block RAM.
//  NREQ requesters each ask for a burst of consecutive words from a base address.
//  The block grants one requester at a time, drives enB/addrB, and returns doutB tagged with the owner id.
//  Sits between the matrix-multiply operand fetch units and the memory; clk drives both this block and the RAM's read clock (clkB).
// PARAMETERS
//  WIDTH  32   data word width; matches the RAM WIDTH
//  DEPTH  512  RAM depth; must be a power of two. AW = $clog2(DEPTH)
//  NREQ   4    number of requesters (>=2). IW = $clog2(NREQ)
//  LW     8    burst-length field width; a burst is len+1 words, 1..2^LW
// PORTS
//  clk        in   1          single clock; also the RAM's clkB
//  rst        in   1          asynchronous, active-high reset
//  req        in   NREQ       per-requester level request; held until done or abort
//  base_addr  in   NREQ*AW    per-requester start address; slice i = [i*AW +: AW]
//  len        in   NREQ*LW    per-requester burst length minus one; slice i = [i*LW +: LW]
//  gnt        out  NREQ       one-hot grant; held for the whole burst
//  done       out  NREQ       one-cycle pulse to the owner, coincident with its last rd_valid
//  mem_en     out  1          to RAM enB
//  mem_addr   out  AW         to RAM addrB
//  mem_dout   in   WIDTH      from RAM doutB (registered; 1-cycle read latency)
//  rd_valid   out  1          rd_data is valid this cycle
//  rd_id      out  IW         index of the requester owning rd_data
//  rd_data    out  WIDTH      combinational pass-through of mem_dout
// BEHAVIOUR
//  Reset: asserting rst clears gnt, done, mem_en, rd_valid and rd_id to 0, mem_addr to 0, and state to IDLE; rr_ptr resets to 0.
//  FSM states:
//   IDLE   no grant. If any req bit is set, select the first set bit at or after rr_ptr (cyclic order).
//          Register gnt, owner id, base and len for that requester; go to BURST.
//   BURST  each cycle: mem_en=1 and mem_addr = base+cnt, computed mod 2^AW so addresses wrap DEPTH-1 -> 0. cnt counts 0..len.
//          After issuing cnt==len: clear gnt, set rr_ptr = owner+1 mod NREQ, go to IDLE.
//  Registered outputs: gnt, mem_en, mem_addr.
//   - mem_en/mem_addr are asserted in the same cycle as the state is BURST.
//   - The first read is issued one cycle after the IDLE cycle that sampled req.
//  Return path:
//   - A 1-cycle pipe, aligned to the RAM latency, carries the valid bit, id and last flag.
//   - rd_valid, rd_id and done are asserted the cycle after the matching mem_en.
//   - done[id] = rd_valid & last.
//  Throughput: one word per cycle within a burst; exactly one IDLE cycle between bursts.
//  Abort: if req[owner] drops while in BURST, that cycle issues no read (mem_en=0).
//   - gnt is cleared, rr_ptr advances past the owner, and state goes to IDLE.
//   - A read already issued still returns rd_valid. No done pulse is produced.
//  Input stability: base_addr[i] and len[i] are sampled only at grant; later changes are ignored.
//  Simultaneous req from several requesters: only one is granted; the others wait. No starvation: with all req
//   held, grants rotate 0,1,..,NREQ-1,0.
//  New req arriving during BURST: does not pre-empt the current burst; it is considered at the next IDLE.
//  Reset mid-burst: everything clears asynchronously. The in-flight RAM read's rd_valid is suppressed; rr_ptr returns to 0.
// TESTING
//  1. Single burst: req[2]=1, base=0x010, len=3 -> mem_addr 0x010..0x013 on 4 consecutive cycles.
//     rd_valid 4 cycles with rd_id=2; done[2] with 4th word.
//  2. Wrap: base=0x1FE, len=3, DEPTH=512 -> mem_addr 0x1FE, 0x1FF, 0x000, 0x001.
//  3. Fairness: all 4 req held, len=0 each -> grant order 0,1,2,3,0,1.
//     Each grant issues 1 read, with 1 IDLE gap between grants.
//  4. Abort: req[1], len=7; drop req[1] after 3 reads -> exactly 3 rd_valid, no done[1], gnt cleared.
//     The next requester is granted after the IDLE cycle.
//  5. Async reset: assert rst mid-burst between clock edges -> gnt, mem_en, rd_valid go 0 immediately.
//     After release with req[3]=1, req[3] is granted (rr_ptr=0 scan).
//  6. Max burst: len=255 -> 256 contiguous reads and 256 rd_valid, done on the last; no gap inside the burst.

Source files
------------

// File: rtl/mem_rd_sched.sv
// Round-robin burst read scheduler for the block RAM read port (port B).
// Grants one requester at a time, streams its burst, and tags returned words with the owner id.
module mem_rd_sched #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 512,
  parameter int NREQ  = 4,
  parameter int LW    = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int IW   = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] base_addr,
  input  logic [NREQ*LW-1:0] len,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic               mem_en,
  output logic [AW-1:0]      mem_addr,
  input  logic [WIDTH-1:0]   mem_dout,
  output logic               rd_valid,
  output logic [IW-1:0]      rd_id,
  output logic [WIDTH-1:0]   rd_data
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state, state_nx;
  logic [NREQ-1:0] gnt_nx;
  logic [IW-1:0]   owner, owner_nx;
  logic [IW-1:0]   rr_ptr, rr_ptr_nx;
  logic [IW-1:0]   sel, idx;
  logic            found;
  logic [LW-1:0]   len_q, cnt, cnt_nx;
  logic            mem_en_nx, load;
  logic [AW-1:0]   mem_addr_nx;
  logic            vld_p1, last_p1;
  logic [IW-1:0]   id_p1;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    if (i == IW'(NREQ - 1)) return '0;
    return i + IW'(1);
  endfunction

  // First requesting index at or after rr_ptr, scanning cyclically.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (int'(rr_ptr) + k >= NREQ) idx = IW'(int'(rr_ptr) + k - NREQ);
      else                          idx = IW'(int'(rr_ptr) + k);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // Next-state logic: mem_en/mem_addr are registered, so they describe the read issued while in BURST.
  always_comb begin
    state_nx    = state;
    gnt_nx      = gnt;
    owner_nx    = owner;
    rr_ptr_nx   = rr_ptr;
    cnt_nx      = cnt;
    mem_en_nx   = 1'b0;
    mem_addr_nx = mem_addr;
    load        = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nx    = BURST;
          gnt_nx      = '0;
          gnt_nx[sel] = 1'b1;
          owner_nx    = sel;
          load        = 1'b1;
          cnt_nx      = '0;
          mem_en_nx   = 1'b1;
          mem_addr_nx = base_addr[int'(sel)*AW +: AW];
        end
      end
      BURST: begin
        if (!req[owner] || cnt == len_q) begin
          state_nx  = IDLE;
          gnt_nx    = '0;
          rr_ptr_nx = next_idx(owner);
        end else begin
          cnt_nx      = cnt + LW'(1);
          mem_en_nx   = 1'b1;
          mem_addr_nx = mem_addr + AW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      owner    <= '0;
      rr_ptr   <= '0;
      cnt      <= '0;
      mem_en   <= 1'b0;
      mem_addr <= '0;
    end else begin
      state    <= state_nx;
      gnt      <= gnt_nx;
      owner    <= owner_nx;
      rr_ptr   <= rr_ptr_nx;
      cnt      <= cnt_nx;
      mem_en   <= mem_en_nx;
      mem_addr <= mem_addr_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (load) len_q <= len[int'(sel)*LW +: LW];
  end

  // Stage p1: return tag aligned with the RAM's one-cycle read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      id_p1   <= '0;
      last_p1 <= 1'b0;
    end else begin
      vld_p1  <= mem_en;
      id_p1   <= owner;
      last_p1 <= mem_en && (cnt == len_q);
    end
  end

  always_comb begin
    done = '0;
    if (vld_p1 && last_p1) done[id_p1] = 1'b1;
  end

  assign rd_valid = vld_p1;
  assign rd_id    = id_p1;
  assign rd_data  = mem_dout;

endmodule

// File: tb/tb_mem_rd_sched.sv
// Bench for mem_rd_sched: a RAM model feeds mem_dout, and a scoreboard of expected
// reads/returns is filled as bursts are requested and drained as the DUT issues and returns them.
module tb_mem_rd_sched;
  localparam int WIDTH = 32;
  localparam int DEPTH = 512;
  localparam int NREQ  = 4;
  localparam int LW    = 8;
  localparam int AW    = 9;
  localparam int IW    = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*AW-1:0] base_addr = '0;
  logic [NREQ*LW-1:0] len = '0;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               mem_en;
  logic [AW-1:0]      mem_addr;
  logic [WIDTH-1:0]   mem_dout = '0;
  logic               rd_valid;
  logic [IW-1:0]      rd_id;
  logic [WIDTH-1:0]   rd_data;

  typedef struct {int id; int addr; bit last;} rd_exp_t;
  rd_exp_t         exp_rd[$];
  int              exp_addr[$];
  int              pass_cnt = 0;
  int              total_cnt = 0;
  int              ea;
  rd_exp_t         er;
  logic [NREQ-1:0] exp_done;

  mem_rd_sched #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ), .LW(LW)) dut (
    .clk(clk), .rst(rst), .req(req), .base_addr(base_addr), .len(len),
    .gnt(gnt), .done(done), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_dout(mem_dout), .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] pat(input int a);
    return 32'hC0DE0000 ^ (32'(a) * 32'h00019E37);
  endfunction

  // RAM port B model: registered read, one-cycle latency.
  always @(posedge clk) if (mem_en) mem_dout <= pat(int'(mem_addr));

  task automatic drive_burst(input int id, input int base, input int ln,
                             output int n_en, output int span, output int lat,
                             output int n_done, output int gnt_bad);
    int first_c, last_c;
    base_addr[id*AW +: AW] = AW'(base);
    len[id*LW +: LW] = LW'(ln);
    for (int i = 0; i <= ln; i++) begin
      exp_addr.push_back((base + i) % DEPTH);
      exp_rd.push_back('{id: id, addr: (base + i) % DEPTH, last: (i == ln)});
    end
    n_en = 0; n_done = 0; gnt_bad = 0; lat = -1; first_c = 0; last_c = 0;
    req[id] = 1'b1;
    for (int c = 0; c < ln + 20; c++) begin
      @(negedge clk);
      if (mem_en) begin
        if (lat < 0) begin lat = c; first_c = c; end
        last_c = c;
        n_en++;
        if (gnt !== (NREQ'(1) << id)) gnt_bad++;
      end
      if (done[id]) begin n_done++; break; end
    end
    req[id] = 1'b0;
    span = last_c - first_c;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b0010;
    repeat (2) @(negedge clk);
    total_cnt++; if (gnt !== '0) $display("FAIL reset_gnt: got %b, required 0000", gnt); else pass_cnt++;
    total_cnt++; if (mem_en !== 1'b0) $display("FAIL reset_mem_en: got %b, required 0", mem_en); else pass_cnt++;
    total_cnt++; if (mem_addr !== '0) $display("FAIL reset_mem_addr: got 0x%0h, required 0x0", mem_addr); else pass_cnt++;
    total_cnt++; if (rd_valid !== 1'b0 || rd_id !== '0) $display("FAIL reset_rd: got valid=%b id=%0d, required 0/0", rd_valid, rd_id); else pass_cnt++;
    total_cnt++; if (done !== '0) $display("FAIL reset_done: got %b, required 0000", done); else pass_cnt++;
    req = '0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_burst();
    int n_en, span, lat, n_done, gnt_bad;
    drive_burst(2, 'h010, 3, n_en, span, lat, n_done, gnt_bad);
    total_cnt++; if (n_en != 4) $display("FAIL single_reads: got %0d, required 4", n_en); else pass_cnt++;
    total_cnt++; if (span != 3) $display("FAIL single_contiguous: got span %0d, required 3", span); else pass_cnt++;
    total_cnt++; if (lat != 0) $display("FAIL single_latency: got %0d, required 0", lat); else pass_cnt++;
    total_cnt++; if (n_done != 1) $display("FAIL single_done: got %0d, required 1", n_done); else pass_cnt++;
    total_cnt++; if (gnt_bad != 0) $display("FAIL single_gnt: got %0d bad cycles, required 0", gnt_bad); else pass_cnt++;
    total_cnt++; if (exp_addr.size() + exp_rd.size() != 0) $display("FAIL single_drain: got %0d pending, required 0", exp_addr.size() + exp_rd.size()); else pass_cnt++;
  endtask

  task automatic test_wrap();
    int n_en, span, lat, n_done, gnt_bad;
    drive_burst(3, 'h1FE, 3, n_en, span, lat, n_done, gnt_bad);
    total_cnt++; if (n_en != 4 || span != 3) $display("FAIL wrap_reads: got %0d reads span %0d, required 4 span 3", n_en, span); else pass_cnt++;
    total_cnt++; if (n_done != 1) $display("FAIL wrap_done: got %0d, required 1", n_done); else pass_cnt++;
    total_cnt++; if (exp_addr.size() + exp_rd.size() != 0) $display("FAIL wrap_drain: got %0d pending, required 0", exp_addr.size() + exp_rd.size()); else pass_cnt++;
  endtask

  task automatic test_fairness();
    int gid[6];
    int gcyc[6];
    int ng;
    for (int i = 0; i < NREQ; i++) begin
      base_addr[i*AW +: AW] = AW'('h040 + 'h10 * i);
      len[i*LW +: LW] = '0;
    end
    for (int i = 0; i < 6; i++) begin
      exp_addr.push_back('h040 + 'h10 * (i % NREQ));
      exp_rd.push_back('{id: i % NREQ, addr: 'h040 + 'h10 * (i % NREQ), last: 1'b1});
    end
    ng = 0;
    req = 4'hF;
    for (int c = 0; c < 40 && ng < 6; c++) begin
      @(negedge clk);
      if (gnt != '0) begin
        gid[ng] = -1;
        for (int k = 0; k < NREQ; k++) if (gnt[k]) gid[ng] = k;
        gcyc[ng] = c;
        ng++;
        if (ng == 6) req = '0;
      end
    end
    req = '0;
    repeat (3) @(negedge clk);
    total_cnt++; if (ng != 6) $display("FAIL fair_count: got %0d grants, required 6", ng); else pass_cnt++;
    for (int i = 0; i < ng; i++) begin
      total_cnt++; if (gid[i] != i % NREQ) $display("FAIL fair_order[%0d]: got %0d, required %0d", i, gid[i], i % NREQ); else pass_cnt++;
    end
    for (int i = 1; i < ng; i++) begin
      total_cnt++; if (gcyc[i] - gcyc[i-1] != 2) $display("FAIL fair_gap[%0d]: got %0d cycles, required 2", i, gcyc[i] - gcyc[i-1]); else pass_cnt++;
    end
    total_cnt++; if (exp_addr.size() + exp_rd.size() != 0) $display("FAIL fair_drain: got %0d pending, required 0", exp_addr.size() + exp_rd.size()); else pass_cnt++;
  endtask

  task automatic test_abort();
    int n;
    int seen3;
    base_addr[1*AW +: AW] = AW'('h080);
    len[1*LW +: LW] = LW'(7);
    base_addr[3*AW +: AW] = AW'('h040);
    len[3*LW +: LW] = '0;
    for (int i = 0; i < 3; i++) begin
      exp_addr.push_back('h080 + i);
      exp_rd.push_back('{id: 1, addr: 'h080 + i, last: 1'b0});
    end
    exp_addr.push_back('h040);
    exp_rd.push_back('{id: 3, addr: 'h040, last: 1'b1});
    n = 0;
    req[1] = 1'b1;
    for (int c = 0; c < 20 && n < 3; c++) begin
      @(negedge clk);
      if (mem_en) n++;
    end
    req[1] = 1'b0;
    req[3] = 1'b1;
    @(negedge clk);
    total_cnt++; if (gnt !== '0 || mem_en !== 1'b0) $display("FAIL abort_idle: got gnt=%b en=%b, required 0000/0", gnt, mem_en); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (gnt !== 4'b1000 || mem_en !== 1'b1) $display("FAIL abort_next_gnt: got gnt=%b en=%b, required 1000/1", gnt, mem_en); else pass_cnt++;
    seen3 = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done[3]) begin seen3 = 1; break; end
    end
    req[3] = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (n != 3) $display("FAIL abort_reads: got %0d, required 3", n); else pass_cnt++;
    total_cnt++; if (seen3 != 1) $display("FAIL abort_next_done: got %0d, required 1", seen3); else pass_cnt++;
    total_cnt++; if (exp_addr.size() + exp_rd.size() != 0) $display("FAIL abort_drain: got %0d pending, required 0", exp_addr.size() + exp_rd.size()); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int n, n_en, span, lat, n_done, gnt_bad;
    base_addr[2*AW +: AW] = AW'('h0A0);
    len[2*LW +: LW] = LW'(7);
    exp_addr.push_back('h0A0);
    exp_addr.push_back('h0A1);
    exp_rd.push_back('{id: 2, addr: 'h0A0, last: 1'b0});
    n = 0;
    req[2] = 1'b1;
    for (int c = 0; c < 10 && n < 2; c++) begin
      @(negedge clk);
      if (mem_en) n++;
    end
    #2 rst = 1'b1;
    #1;
    total_cnt++; if (n != 2) $display("FAIL arst_pre_reads: got %0d, required 2", n); else pass_cnt++;
    total_cnt++; if (gnt !== '0 || mem_en !== 1'b0) $display("FAIL arst_clear: got gnt=%b en=%b, required 0000/0", gnt, mem_en); else pass_cnt++;
    total_cnt++; if (rd_valid !== 1'b0 || done !== '0) $display("FAIL arst_rd: got valid=%b done=%b, required 0/0000", rd_valid, done); else pass_cnt++;
    req[2] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    drive_burst(3, 'h0C0, 1, n_en, span, lat, n_done, gnt_bad);
    total_cnt++; if (lat != 0 || n_en != 2) $display("FAIL arst_regrant: got lat=%0d reads=%0d, required 0/2", lat, n_en); else pass_cnt++;
    total_cnt++; if (n_done != 1 || gnt_bad != 0) $display("FAIL arst_done: got done=%0d gnt_bad=%0d, required 1/0", n_done, gnt_bad); else pass_cnt++;
    total_cnt++; if (exp_addr.size() + exp_rd.size() != 0) $display("FAIL arst_drain: got %0d pending, required 0", exp_addr.size() + exp_rd.size()); else pass_cnt++;
  endtask

  task automatic test_max_burst();
    int n_en, span, lat, n_done, gnt_bad;
    drive_burst(0, 'h100, 255, n_en, span, lat, n_done, gnt_bad);
    total_cnt++; if (n_en != 256) $display("FAIL max_reads: got %0d, required 256", n_en); else pass_cnt++;
    total_cnt++; if (span != 255) $display("FAIL max_contiguous: got span %0d, required 255", span); else pass_cnt++;
    total_cnt++; if (n_done != 1 || gnt_bad != 0) $display("FAIL max_done: got done=%0d gnt_bad=%0d, required 1/0", n_done, gnt_bad); else pass_cnt++;
    total_cnt++; if (exp_addr.size() + exp_rd.size() != 0) $display("FAIL max_drain: got %0d pending, required 0", exp_addr.size() + exp_rd.size()); else pass_cnt++;
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (mem_en) begin
          total_cnt++;
          if (exp_addr.size() == 0) begin
            $display("FAIL sb_issue: got read at 0x%0h, required no read", mem_addr);
          end else begin
            ea = exp_addr.pop_front();
            if (mem_addr !== AW'(ea)) $display("FAIL sb_addr: got 0x%0h, required 0x%0h", mem_addr, ea);
            else pass_cnt++;
          end
        end
        if (rd_valid) begin
          total_cnt++;
          if (exp_rd.size() == 0) begin
            $display("FAIL sb_return: got rd_valid id=%0d, required none", rd_id);
          end else begin
            er = exp_rd.pop_front();
            exp_done = er.last ? (NREQ'(1) << er.id) : '0;
            if (rd_id !== IW'(er.id) || rd_data !== pat(er.addr) || done !== exp_done)
              $display("FAIL sb_data: got id=%0d data=0x%0h done=%b, required id=%0d data=0x%0h done=%b",
                       rd_id, rd_data, done, er.id, pat(er.addr), exp_done);
            else pass_cnt++;
          end
        end
      end
    join_none
    test_reset();
    test_single_burst();
    test_wrap();
    test_fairness();
    test_abort();
    test_async_reset();
    test_max_burst();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

endmodule
